// File: rtl/watch_set_if.sv
// Handshake bundle between the watch-setting controller and the board/watch.
//   btn_mode, btn_up : raw push buttons, active-high, asynchronous to clk
//   cur_time         : live BCD time {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//   run_en           : watch count enable
//   load, load_time  : one-cycle write-back strobe and BCD time to load
//   blank_mask       : per-digit blank request, bit 5 = h_ten .. bit 0 = s_one
//   mode             : 00 RUN, 01 SET_HOUR, 10 SET_MIN, 11 SET_SEC
// master = board/watch side, slave = controller side.
interface watch_set_if;
  logic        btn_mode;
  logic        btn_up;
  logic [23:0] cur_time;
  logic        run_en;
  logic        load;
  logic [23:0] load_time;
  logic [5:0]  blank_mask;
  logic [1:0]  mode;

  modport master (
    output btn_mode, btn_up, cur_time,
    input  run_en, load, load_time, blank_mask, mode
  );

  modport slave (
    input  btn_mode, btn_up, cur_time,
    output run_en, load, load_time, blank_mask, mode
  );
endinterface

// File: rtl/watch_set_ctrl.sv
// Button-driven time-setting controller for the 24-hour watch counter.
// Debounces the mode/up buttons, steps RUN -> SET_HOUR -> SET_MIN -> SET_SEC
// -> RUN, edits a captured copy of the time while the watch is frozen, and
// writes it back with a one-cycle load strobe. Idle set modes time out.
// Ports:
//   clk  : 1 kHz system clock
//   rst  : asynchronous, active-high reset
//   bus  : watch_set_if.slave (buttons, cur_time in; run_en, load,
//          load_time, blank_mask, mode out)
// Optional feature: define WATCH_SET_BLINK_EN to blink the edited field via
// blank_mask; without it blank_mask is constant 0.
module watch_set_ctrl #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned BLINK_HALF  = 250,
  parameter int unsigned TIMEOUT_MS  = 30000
) (
  input  logic        clk,
  input  logic        rst,
  watch_set_if.slave  bus
);

  localparam int unsigned DB_W = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int unsigned TO_W = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_HOUR = 2'b01,
    S_MIN  = 2'b10,
    S_SEC  = 2'b11
  } state_t;

  state_t          state;
  logic            run_en_q;
  logic            load_q;
  logic [23:0]     edit_q;
  logic [TO_W-1:0] to_cnt;

  logic [1:0]      raw_c;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      level_q;
  logic [1:0]      press_q;
  logic [DB_W-1:0] db_cnt_q [2];

  logic            mode_p;
  logic            up_p;
  logic            timeout_c;

  // Hours +1 on a BCD pair; anything at or past 23 wraps to 00.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v[7:4] > 4'd2 || (v[7:4] == 4'd2 && v[3:0] >= 4'd3))
      inc_hour = 8'h00;
    else if (v[3:0] >= 4'd9)
      inc_hour = {v[7:4] + 4'd1, 4'd0};
    else
      inc_hour = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Minutes/seconds +1 on a BCD pair; anything at or past 59 wraps to 00.
  function automatic logic [7:0] inc_sexa(input logic [7:0] v);
    if (v[7:4] > 4'd5 || (v[7:4] == 4'd5 && v[3:0] >= 4'd9))
      inc_sexa = 8'h00;
    else if (v[3:0] >= 4'd9)
      inc_sexa = {v[7:4] + 4'd1, 4'd0};
    else
      inc_sexa = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Bit 0 = mode button, bit 1 = up button.
  assign raw_c = {bus.btn_up, bus.btn_mode};

  // Synchronizer + stable-count debounce; press pulse on accepted rising level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_MS - 1)) begin
          db_cnt_q[i] <= '0;
          level_q[i]  <= sync2_q[i];
          press_q[i]  <= sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign mode_p = press_q[0];
  assign up_p   = press_q[1];

  // Idle exit: only when no press arrives in the terminal-count cycle.
  assign timeout_c = (state != S_RUN) && !mode_p && !up_p &&
                     (to_cnt == TO_W'(TIMEOUT_MS - 1));

  // Mode FSM with edit register, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      run_en_q <= 1'b1;
      load_q   <= 1'b0;
      edit_q   <= '0;
      to_cnt   <= '0;
    end else begin
      load_q <= 1'b0;
      if (state == S_RUN) begin
        to_cnt <= '0;
        if (mode_p) begin
          edit_q   <= bus.cur_time;
          state    <= S_HOUR;
          run_en_q <= 1'b0;
        end
      end else if (mode_p) begin
        // Mode wins over a coincident up press.
        to_cnt <= '0;
        case (state)
          S_HOUR:  state <= S_MIN;
          S_MIN:   state <= S_SEC;
          default: begin
            state    <= S_RUN;
            run_en_q <= 1'b1;
            load_q   <= 1'b1;
          end
        endcase
      end else if (up_p) begin
        to_cnt <= '0;
        case (state)
          S_HOUR:  edit_q[23:16] <= inc_hour(edit_q[23:16]);
          S_MIN:   edit_q[15:8]  <= inc_sexa(edit_q[15:8]);
          default: edit_q[7:0]   <= inc_sexa(edit_q[7:0]);
        endcase
      end else if (timeout_c) begin
        // Abandon the edit; the watch resumes from its frozen value.
        state    <= S_RUN;
        run_en_q <= 1'b1;
        to_cnt   <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  assign bus.run_en    = run_en_q;
  assign bus.load      = load_q;
  assign bus.load_time = edit_q;
  assign bus.mode      = state;

`ifdef WATCH_SET_BLINK_EN
  localparam int unsigned BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BL_W-1:0] blink_cnt;
  logic            blink_ph;
  logic [5:0]      blank_q;
  logic [5:0]      field_c;

  // Digits of the field being edited.
  always_comb begin
    field_c = 6'b000000;
    case (state)
      S_HOUR:  field_c = 6'b110000;
      S_MIN:   field_c = 6'b001100;
      S_SEC:   field_c = 6'b000011;
      default: field_c = 6'b000000;
    endcase
  end

  // Every mode press and timeout changes state, so both restart the blink
  // visible; the mask is built from the post-edge phase so it never lags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      blank_q   <= '0;
    end else if (mode_p || up_p || timeout_c) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      blank_q   <= '0;
    end else if (blink_cnt == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
      blank_q   <= blink_ph ? 6'b000000 : field_c;
    end else begin
      blink_cnt <= blink_cnt + BL_W'(1);
      blank_q   <= blink_ph ? field_c : 6'b000000;
    end
  end

  assign bus.blank_mask = blank_q;
`else
  // Blink logic compiled out: every digit stays lit.
  assign bus.blank_mask = 6'(BLINK_HALF) & 6'b000000;
`endif

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Self-checking bench for watch_set_ctrl: directed passes plus randomized
// button presses checked against a time-arithmetic reference model.
module tb_watch_set_ctrl;

  localparam int DB = 20;
  localparam int BH = 250;
  localparam int TO = 30000;

  logic clk;
  logic rst;
  watch_set_if bus ();

  watch_set_ctrl #(
    .DEBOUNCE_MS(DB),
    .BLINK_HALF (BH),
    .TIMEOUT_MS (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: mode code, edited time, live time, load count.
  int m_mode  = 0;
  int e_h     = 0;
  int e_m     = 0;
  int e_s     = 0;
  int cur_h   = 0;
  int cur_m   = 0;
  int cur_s   = 0;
  int m_loads = 0;

  // Load monitor.
  int          load_cnt = 0;
  logic [23:0] last_load_time = '0;
  logic        last_run_en = 1'b0;

  always @(negedge clk) begin
    if (bus.load === 1'b1) begin
      load_cnt++;
      last_load_time = bus.load_time;
      last_run_en    = bus.run_en;
    end
  end

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model reaction to one debounced press (or coincident pair).
  task automatic model_press(input bit m, input bit u, output bit exp_load);
    exp_load = 1'b0;
    if (m) begin
      case (m_mode)
        0: begin e_h = cur_h; e_m = cur_m; e_s = cur_s; m_mode = 1; end
        1: m_mode = 2;
        2: m_mode = 3;
        default: begin m_mode = 0; exp_load = 1'b1; m_loads++; end
      endcase
    end else if (u) begin
      case (m_mode)
        1: e_h = (e_h + 1) % 24;
        2: e_m = (e_m + 1) % 60;
        3: e_s = (e_s + 1) % 60;
        default: ;
      endcase
    end
  endtask

  // Clean press held until accepted, then released. Call right after a negedge.
  task automatic press(input bit m, input bit u, input string tag);
    int om;
    bit el;
    om = m_mode;
    bus.btn_mode = m;
    bus.btn_up   = u;
    repeat (DB + 2) @(posedge clk);
    @(negedge clk);
    check({tag, "_mode_early"}, 32'(bus.mode), 32'(om));
    model_press(m, u, el);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_mode"}, 32'(bus.mode), 32'(m_mode));
    check({tag, "_run_en"}, 32'(bus.run_en), 32'(m_mode == 0));
    check({tag, "_load"}, 32'(bus.load), 32'(el));
    check({tag, "_blank"}, 32'(bus.blank_mask), 32'(0));
    if (m_mode != 0 || el)
      check({tag, "_time"}, 32'(bus.load_time), 32'(to_bcd(e_h, e_m, e_s)));
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    repeat (DB + 4) @(negedge clk);
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
    bus.cur_time = to_bcd(h, m, s);
  endtask

  initial begin
    int k;
    logic [5:0] exp_mask;

    rst          = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.cur_time = '0;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_mode", 32'(bus.mode), 32'(0));
    check("rst_run_en", 32'(bus.run_en), 32'(1));
    check("rst_load", 32'(bus.load), 32'(0));
    check("rst_load_time", 32'(bus.load_time), 32'(0));
    check("rst_blank", 32'(bus.blank_mask), 32'(0));
    rst = 1'b0;

    // Idle with buttons low.
    repeat (100) @(negedge clk);
    check("idle_mode", 32'(bus.mode), 32'(0));
    check("idle_run_en", 32'(bus.run_en), 32'(1));
    check("idle_blank", 32'(bus.blank_mask), 32'(0));
    check("idle_loads", 32'(load_cnt), 32'(0));

    // Full edit pass from 12:34:56 to 01:00:00; live time moves meanwhile.
    set_cur(12, 34, 56);
    press(1, 0, "pass_enter");
    set_cur(5, 6, 7);
    for (int i = 0; i < 13; i++) press(0, 1, "pass_hour_up");
    press(1, 0, "pass_to_min");
    for (int i = 0; i < 26; i++) press(0, 1, "pass_min_up");
    press(1, 0, "pass_to_sec");
    for (int i = 0; i < 4; i++) press(0, 1, "pass_sec_up");
    press(1, 0, "pass_exit");
    repeat (3) @(negedge clk);
    check("pass_load_count", 32'(load_cnt), 32'(1));
    check("pass_load_time", 32'(last_load_time), 32'h010000);
    check("pass_load_run_en", 32'(last_run_en), 32'(1));
    check("pass_load_single", 32'(bus.load), 32'(0));

    // Short bounce on mode is rejected.
    bus.btn_mode = 1'b1;
    repeat (5) @(negedge clk);
    bus.btn_mode = 1'b0;
    repeat (2 * DB) @(negedge clk);
    check("bounce_mode", 32'(bus.mode), 32'(0));
    check("bounce_run_en", 32'(bus.run_en), 32'(1));

    // Coincident mode+up in SET_MIN: mode wins, minutes stay 07.
    set_cur(9, 7, 30);
    press(1, 0, "simul_enter");
    press(1, 0, "simul_to_min");
    press(1, 1, "simul_both");
    check("simul_minutes", 32'(bus.load_time[15:8]), 32'h07);
    press(1, 0, "simul_exit");

    // Randomized presses against the model.
    for (int i = 0; i < 40; i++) begin
      set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
              int'($urandom_range(0, 59)));
      k = int'($urandom_range(0, 9));
      if (k < 3)      press(1, 0, "rnd_mode");
      else if (k < 9) press(0, 1, "rnd_up");
      else            press(1, 1, "rnd_both");
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    while (m_mode != 0) press(1, 0, "rnd_drain");
    check("rnd_load_count", 32'(load_cnt), 32'(m_loads));

    // Blink in SET_MIN: edge of entry is k=0; press returns at k=DB+4.
`ifdef WATCH_SET_BLINK_EN
    exp_mask = 6'b001100;
`else
    exp_mask = 6'b000000;
`endif
    set_cur(8, 15, 0);
    press(1, 0, "blink_enter");
    press(1, 0, "blink_to_min");
    repeat (BH - 1 - (DB + 4)) @(negedge clk);
    check("blink_vis1", 32'(bus.blank_mask), 32'(0));
    @(negedge clk);
    check("blink_dark1", 32'(bus.blank_mask), 32'(exp_mask));
    repeat (BH - 1) @(negedge clk);
    check("blink_dark2", 32'(bus.blank_mask), 32'(exp_mask));
    @(negedge clk);
    check("blink_vis2", 32'(bus.blank_mask), 32'(0));
    repeat (BH / 2) @(negedge clk);
    press(0, 1, "blink_up");
    press(1, 0, "blink_to_sec");
    press(1, 0, "blink_exit");

    // Timeout from SET_HOUR: exit exactly TO edges after entry, no load.
    k = load_cnt;
    press(1, 0, "to_enter");
    repeat (TO - 1 - (DB + 4)) @(negedge clk);
    check("to_mode_before", 32'(bus.mode), 32'(1));
    check("to_run_en_before", 32'(bus.run_en), 32'(0));
    @(negedge clk);
    m_mode = 0;
    check("to_mode_after", 32'(bus.mode), 32'(0));
    check("to_run_en_after", 32'(bus.run_en), 32'(1));
    repeat (5) @(negedge clk);
    check("to_no_load", 32'(load_cnt), 32'(k));

    // Reset in SET_MIN aborts immediately without a load.
    k = load_cnt;
    set_cur(20, 40, 10);
    press(1, 0, "rab_enter");
    press(1, 0, "rab_to_min");
    press(0, 1, "rab_up");
    rst = 1'b1;
    #1;
    m_mode = 0;
    check("rab_mode", 32'(bus.mode), 32'(0));
    check("rab_run_en", 32'(bus.run_en), 32'(1));
    check("rab_load", 32'(bus.load), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rab_mode_after", 32'(bus.mode), 32'(0));
    check("rab_no_load", 32'(load_cnt), 32'(k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
